mips_cpu_lsu: RTL and testbench
===============================

# mips_cpu_lsu

Load/store unit between the MIPS core's execute/memory stage and the 32-bit memory bus. Accepts one load or store request at a time from the core, drives a single bus transaction with the correct word address, byte lanes and lane-aligned write data, and honours `waitrequest`. For loads, it returns a sign- or zero-extended result. Sits directly upstream of the RAM/bus slave.

## Interface
Parameters:
- `RESET_VECTOR`, `32'hBFC00000`: value driven on `avm_address` while idle and after reset.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  LSU can accept a request (high only in IDLE).
- `req_op`  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle pulse: request complete.
- `resp_rdata`  out  32  extended load result; 0 for stores.
- `resp_err`  out  1  misalignment error; valid with `resp_valid`.
- `avm_address`  out  32  word address, bits [1:0] always 0.
- `avm_read`  out  1  bus read strobe.
- `avm_write`  out  1  bus write strobe.
- `avm_writedata`  out  32  lane-aligned write data.
- `avm_byteenable`  out  4  active byte lanes.
- `avm_waitrequest`  in  1  slave stall.
- `avm_readdata`  in  32  read data; valid exactly 1 cycle after a read is accepted.

## Operation
- FSM states: IDLE, BUS, RDWAIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, capture op, addr and wdata, compute lanes, and go to BUS. Error case: see Configuration.
- **BUS**
  - Drive `avm_read` (loads) or `avm_write` (stores); hold all bus outputs stable while `avm_waitrequest`=1.
  - When `avm_waitrequest`=0: loads go to RDWAIT, stores go to RESP.
- **RDWAIT**
  - Capture `avm_readdata`, then go to RESP.
- **RESP**
  - Assert `resp_valid` for one cycle, then go to IDLE.
- **Lane mapping**
  - Little-endian: byte offset `o`=addr[1:0].
  - Byte: lane `o`, `byteenable`=`4'b0001<<o`.
  - Half: lanes `o`,`o+1`, `byteenable`=`4'b0011<<o`.
  - Word: `4'b1111`.
  - `avm_writedata` = `req_wdata` shifted left by `8*o`; unused lanes are 0.
- **Load extension**
  - Selected bytes are shifted down by `8*o`.
  - LB and LH sign-extend from bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
- **Alignment**: halfwords need addr[0]=0; words need addr[1:0]=0.
- At most one outstanding transaction. `req_valid` outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE; `req_ready`=1.
  - `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.
  - `avm_read`=0, `avm_write`=0, `avm_writedata`=0, `avm_byteenable`=0.
  - `avm_address`=`RESET_VECTOR`.
- Latency from request acceptance to `resp_valid`, with `waitrequest` held low:
  - Load: 3 cycles.
  - Store: 2 cycles.
  - Each `waitrequest`-high cycle adds 1.
- `avm_read`/`avm_write` are registered, deassert the cycle after acceptance, and are never both high.
- `reset_n` low mid-transaction: immediate return to reset values; no response is issued. The bus strobe drops asynchronously.
- The request is registered, so `req_addr` may change after acceptance without effect.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined**
  - A misaligned LH/LHU/SH/LW/SW goes IDLE→RESP with no bus access.
  - `resp_err`=1, `resp_rdata`=0.
- **Not defined**
  - Misalignment is ignored: halfword uses addr[1]<<1 as offset, word uses offset 0.
  - `resp_err` is tied 0.

## Test plan
- **LW, no stall**: `req_op`=100, addr=`BFC00010`, `readdata`=`8badf00d`, `waitrequest`=0.
  - `avm_address`=`BFC00010`, `byteenable`=1111, `avm_read` high for 1 cycle.
  - `resp_valid` 3 cycles after acceptance with `resp_rdata`=`8badf00d`.
- **LB/LBU sign handling**: addr=`BFC00013`, `readdata`=`80112233`.
  - LB → `ffffff80`, LBU → `00000080`.
  - `byteenable`=1000 for both.
- **SH with 2 waitrequest cycles**: addr=`BFC00022`, wdata=`0000abcd`.
  - `avm_write` held 3 cycles with `writedata`=`abcd0000`, `byteenable`=1100.
  - `resp_valid` 4 cycles after acceptance.
- **Misaligned SW**: addr=`BFC00001`.
  - With `LSU_MISALIGN_TRAP_EN`: no `avm_write`, `resp_err`=1.
  - Without it: `avm_address`=`BFC00000`, `byteenable`=1111.
- **Reset mid-read**: `reset_n` low during BUS with `waitrequest`=1.
  - `avm_read`=0 immediately, no `resp_valid`, `req_ready`=1 after release.
- **Back-to-back SB then LHU**: second request is accepted only when `req_ready` returns high.
  - The LHU reads the stored byte correctly zero-extended.

Source files
------------

// File: rtl/mips_cpu_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_lsu
// Purpose  : Load/store unit between the MIPS core execute/memory stage and a
//            32-bit Avalon-MM style memory bus. Accepts one request at a time,
//            issues a single bus transaction with word address, byte lanes and
//            lane-aligned write data, honours waitrequest, and returns a
//            sign/zero-extended load result.
// Ports    : clk, reset_n (async, active low)
//            req_valid/req_ready/req_op/req_addr/req_wdata : core request
//            resp_valid/resp_rdata/resp_err                 : core response
//            avm_address/avm_read/avm_write/avm_writedata/
//            avm_byteenable/avm_waitrequest/avm_readdata    : memory bus
// Config   : define LSU_MISALIGN_TRAP_EN to turn misaligned halfword/word
//            accesses into an error response with no bus access; otherwise
//            the low address bits are ignored and resp_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_lsu #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    localparam logic [1:0] c_sz_byte = 2'd0;
    localparam logic [1:0] c_sz_half = 2'd1;
    localparam logic [1:0] c_sz_word = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUS    = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Captured request
    logic [29:0] r_addr_word;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_is_store;

    // Registered bus drive and load result
    logic        r_avm_read;
    logic        r_avm_write;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_rdata;

    // Request decode
    logic [1:0]  w_size;
    logic        w_is_store;
    logic        w_signed;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_lane_mask;
    logic [31:0] w_wdata;
    logic        w_trap;

    // Load extraction
    logic [31:0] w_rd_shift;
    logic [31:0] w_load_ext;

    always_comb begin
        w_size     = c_sz_word;
        w_is_store = 1'b0;
        w_signed   = 1'b0;
        case (req_op)
            3'b000: begin w_size = c_sz_byte; w_signed = 1'b1; end
            3'b001: begin w_size = c_sz_byte; end
            3'b010: begin w_size = c_sz_half; w_signed = 1'b1; end
            3'b011: begin w_size = c_sz_half; end
            3'b100: begin w_size = c_sz_word; end
            3'b101: begin w_size = c_sz_byte; w_is_store = 1'b1; end
            3'b110: begin w_size = c_sz_half; w_is_store = 1'b1; end
            3'b111: begin w_size = c_sz_word; w_is_store = 1'b1; end
        endcase
    end

    // Halfwords drop addr[0] and words drop addr[1:0]; in the trapping build
    // those accesses never reach the bus, so the same offset rule serves both.
    always_comb begin
        w_off = 2'b00;
        w_be  = 4'b1111;
        case (w_size)
            c_sz_byte: begin
                w_off = req_addr[1:0];
                w_be  = 4'b0001 << w_off;
            end
            c_sz_half: begin
                w_off = {req_addr[1], 1'b0};
                w_be  = 4'b0011 << w_off;
            end
            default: begin
                w_off = 2'b00;
                w_be  = 4'b1111;
            end
        endcase
    end

    // Mask after shifting so stray upper bits of the right-justified store
    // data never leak into lanes that are not enabled.
    assign w_lane_mask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
    assign w_wdata     = (req_wdata << {w_off, 3'b000}) & w_lane_mask;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = ((w_size == c_sz_half) && req_addr[0]) ||
                    ((w_size == c_sz_word) && (req_addr[1:0] != 2'b00));
`else
    assign w_trap = 1'b0;
`endif

    assign w_rd_shift = avm_readdata >> {r_off, 3'b000};

    always_comb begin
        w_load_ext = w_rd_shift;
        case (r_size)
            c_sz_byte: w_load_ext = {{24{r_signed & w_rd_shift[7]}},  w_rd_shift[7:0]};
            c_sz_half: w_load_ext = {{16{r_signed & w_rd_shift[15]}}, w_rd_shift[15:0]};
            default:   w_load_ext = w_rd_shift;
        endcase
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_nxt = w_trap ? RESP : BUS;
                end
            end
            BUS: begin
                if (!avm_waitrequest) begin
                    w_state_nxt = r_is_store ? RESP : RDWAIT;
                end
            end
            RDWAIT:  w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, bus drive and load result
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr_word <= '0;
            r_off       <= 2'b00;
            r_size      <= c_sz_byte;
            r_signed    <= 1'b0;
            r_is_store  <= 1'b0;
            r_avm_read  <= 1'b0;
            r_avm_write <= 1'b0;
            r_wdata     <= '0;
            r_be        <= 4'b0000;
            r_rdata     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr_word <= req_addr[31:2];
                        r_off       <= w_off;
                        r_size      <= w_size;
                        r_signed    <= w_signed;
                        r_is_store  <= w_is_store;
                        r_rdata     <= '0;
                        if (!w_trap) begin
                            r_avm_read  <= ~w_is_store;
                            r_avm_write <= w_is_store;
                            r_wdata     <= w_wdata;
                            r_be        <= w_be;
                        end
                    end
                end
                BUS: begin
                    // Everything stays frozen while the slave stalls.
                    if (!avm_waitrequest) begin
                        r_avm_read  <= 1'b0;
                        r_avm_write <= 1'b0;
                        r_wdata     <= '0;
                        r_be        <= 4'b0000;
                    end
                end
                RDWAIT: begin
                    r_rdata <= w_load_ext;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if ((r_state == IDLE) && req_valid) begin
            r_err <= w_trap;
        end
    end

    assign resp_err = r_err;
`else
    assign resp_err = 1'b0;
`endif

    assign req_ready      = (r_state == IDLE);
    assign resp_valid     = (r_state == RESP);
    assign resp_rdata     = r_rdata;
    assign avm_address    = (r_state == IDLE) ? {RESET_VECTOR[31:2], 2'b00}
                                              : {r_addr_word, 2'b00};
    assign avm_read       = r_avm_read;
    assign avm_write      = r_avm_write;
    assign avm_writedata  = r_wdata;
    assign avm_byteenable = r_be;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_cpu_lsu
// Purpose  : Self-checking bench for mips_cpu_lsu. A byte-array reference
//            memory predicts bus lanes, write data and load results; a bus
//            slave with its own word memory answers the DUT. Directed cases
//            pin literal values, then randomized back-to-back traffic runs
//            with random waitrequest stalls.
// Config   : honours LSU_MISALIGN_TRAP_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_lsu;

    localparam logic [31:0] RV = 32'hBFC00000;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    mips_cpu_lsu #(.RESET_VECTOR(RV)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_byteenable (avm_byteenable),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata   (avm_readdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Bus slave state
    logic [31:0] bus_mem [0:63];
    bit          pend_rd;
    int          pend_idx;
    int          force_stalls;
    bit          rand_stall;

    // Reference model: byte-addressed memory plus one open transaction
    logic [7:0]  ref_bytes [0:255];
    bit          txn;
    int          t_acc;
    int          stalls;
    bit          bus_done;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;
    bit          m_store, m_trap;
    bit          exp_busy, exp_strobe, exp_resp;

    // Observations for directed literal checks
    bit          obs_done;
    int          obs_lat, obs_strobes;
    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic [3:0]  obs_be;
    logic        obs_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] w);
        bus_mem[idx] = w;
        for (int k = 0; k < 4; k++) ref_bytes[idx*4 + k] = w[8*k +: 8];
    endtask

    // Spec-level prediction of one request from size/offset arithmetic.
    task automatic predict(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        int          n, o;
        logic [31:0] ea, v;
        bit          sgn, mis;
        n = (op == 3'd0 || op == 3'd1 || op == 3'd5) ? 1 :
            (op == 3'd2 || op == 3'd3 || op == 3'd6) ? 2 : 4;
        m_store = (op >= 3'd5);
        sgn     = (op == 3'd0 || op == 3'd2);
        mis     = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
        m_trap  = mis && TRAP_EN;
        ea      = (n == 1) ? addr : (n == 2) ? (addr & ~32'd1) : (addr & ~32'd3);
        o       = int'(ea[1:0]);
        m_addr  = addr & ~32'd3;
        m_be    = 4'b0000;
        m_wdata = 32'd0;
        v       = 32'd0;
        for (int k = 0; k < n; k++) begin
            m_be[o+k]              = 1'b1;
            m_wdata[8*(o+k) +: 8]  = wd[8*k +: 8];
            v[8*k +: 8]            = ref_bytes[ea[7:0] + 8'(k)];
        end
        if (sgn && v[8*n-1]) begin
            for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        end
        m_rdata = (m_store || m_trap) ? 32'd0 : v;
        if (m_store && !m_trap) begin
            for (int k = 0; k < n; k++) ref_bytes[ea[7:0] + 8'(k)] = wd[8*k +: 8];
        end
    endtask

    // Slave + compare process: everything observed on the falling edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            txn             = 1'b0;
            pend_rd         = 1'b0;
            force_stalls    = 0;
            avm_waitrequest = 1'b0;
        end else begin
            cyc++;
            avm_readdata = pend_rd ? bus_mem[pend_idx] : $urandom;
            if (avm_read || avm_write) begin
                if (force_stalls > 0) begin
                    avm_waitrequest = 1'b1;
                    force_stalls--;
                end else begin
                    avm_waitrequest = rand_stall && ($urandom_range(0, 2) == 0);
                end
            end else begin
                avm_waitrequest = 1'($urandom_range(0, 1));
            end

            exp_busy   = txn && (cyc > t_acc);
            exp_strobe = exp_busy && !bus_done && !m_trap;
            exp_resp   = exp_busy &&
                         (cyc == t_acc + (m_trap ? 1 : (m_store ? 2 : 3)) + stalls);

            chk("req_ready",  req_ready,  !exp_busy);
            chk("avm_read",   avm_read,   exp_strobe && !m_store);
            chk("avm_write",  avm_write,  exp_strobe && m_store);
            chk("resp_valid", resp_valid, exp_resp);
            if (!exp_busy) chk("idle_address", avm_address, RV);

            if (avm_read || avm_write) begin
                obs_strobes++;
                obs_addr  = avm_address;
                obs_be    = avm_byteenable;
                obs_wdata = avm_writedata;
            end
            if (exp_strobe) begin
                chk("avm_address",    avm_address,    m_addr);
                chk("avm_byteenable", avm_byteenable, m_be);
                if (m_store) chk("avm_writedata", avm_writedata, m_wdata);
                if (avm_waitrequest) stalls++;
                else bus_done = 1'b1;
            end
            if (resp_valid) begin
                obs_done  = 1'b1;
                obs_lat   = cyc - t_acc;
                obs_rdata = resp_rdata;
                obs_err   = resp_err;
            end
            if (exp_resp) begin
                chk("resp_rdata", resp_rdata, m_rdata);
                chk("resp_err",   resp_err,   m_trap);
                txn = 1'b0;
            end else if (txn && (cyc > t_acc + 100)) begin
                chk("txn_timeout", 32'd0, 32'd1);
                txn = 1'b0;
            end

            if (req_valid && !exp_busy) begin
                predict(req_op, req_addr, req_wdata);
                txn         = 1'b1;
                t_acc       = cyc;
                stalls      = 0;
                bus_done    = 1'b0;
                obs_done    = 1'b0;
                obs_strobes = 0;
            end

            pend_rd  = avm_read && !avm_waitrequest;
            pend_idx = int'(avm_address[7:2]);
            if (avm_write && !avm_waitrequest) begin
                for (int i = 0; i < 4; i++)
                    if (avm_byteenable[i]) bus_mem[pend_idx][8*i +: 8] = avm_writedata[8*i +: 8];
            end
        end
    end

    task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        // Request is registered: scramble the inputs right after acceptance.
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 100 && !obs_done; i++) @(posedge clk);
        chk("resp_seen", obs_done, 1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        reset_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'd0;
        req_wdata = 32'd0; avm_waitrequest = 1'b0; avm_readdata = 32'd0;
        rand_stall = 1'b0; force_stalls = 0;

        repeat (2) @(posedge clk); #1;
        chk("rst_req_ready",  req_ready,      1);
        chk("rst_resp_valid", resp_valid,     0);
        chk("rst_resp_err",   resp_err,       0);
        chk("rst_resp_rdata", resp_rdata,     0);
        chk("rst_avm_read",   avm_read,       0);
        chk("rst_avm_write",  avm_write,      0);
        chk("rst_writedata",  avm_writedata,  0);
        chk("rst_byteenable", avm_byteenable, 0);
        chk("rst_address",    avm_address,    RV);
        @(negedge clk); #2 reset_n = 1'b1;

        // LW, no stall
        preload(4, 32'h8badf00d);
        do_req(3'b100, 32'hBFC00010, 32'd0);
        wait_resp();
        chk("lw_rdata",   obs_rdata,   32'h8badf00d);
        chk("lw_latency", obs_lat,     3);
        chk("lw_address", obs_addr,    32'hBFC00010);
        chk("lw_be",      obs_be,      4'b1111);
        chk("lw_strobes", obs_strobes, 1);

        // LB / LBU sign handling
        preload(4, 32'h80112233);
        do_req(3'b000, 32'hBFC00013, 32'd0);
        wait_resp();
        chk("lb_rdata", obs_rdata, 32'hffffff80);
        chk("lb_be",    obs_be,    4'b1000);
        do_req(3'b001, 32'hBFC00013, 32'd0);
        wait_resp();
        chk("lbu_rdata", obs_rdata, 32'h00000080);
        chk("lbu_be",    obs_be,    4'b1000);

        // SH with two waitrequest cycles
        force_stalls = 2;
        do_req(3'b110, 32'hBFC00022, 32'h0000abcd);
        wait_resp();
        chk("sh_strobes",   obs_strobes, 3);
        chk("sh_writedata", obs_wdata,   32'habcd0000);
        chk("sh_be",        obs_be,      4'b1100);
        chk("sh_latency",   obs_lat,     4);
        chk("sh_rdata",     obs_rdata,   0);

        // Misaligned SW
        do_req(3'b111, 32'hBFC00001, 32'h12345678);
        wait_resp();
`ifdef LSU_MISALIGN_TRAP_EN
        chk("msw_strobes", obs_strobes, 0);
        chk("msw_err",     obs_err,     1);
        chk("msw_latency", obs_lat,     1);
`else
        chk("msw_address", obs_addr,    32'hBFC00000);
        chk("msw_be",      obs_be,      4'b1111);
        chk("msw_strobes", obs_strobes, 1);
        chk("msw_err",     obs_err,     0);
`endif

        // Reset in the middle of a stalled read
        force_stalls = 1000;
        do_req(3'b100, 32'hBFC00014, 32'd0);
        @(posedge clk); #2;
        chk("rstmid_pre_read", avm_read, 1);
        reset_n = 1'b0;
        #1;
        chk("rstmid_read",    avm_read,    0);
        chk("rstmid_resp",    resp_valid,  0);
        chk("rstmid_ready",   req_ready,   1);
        chk("rstmid_address", avm_address, RV);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (6) @(posedge clk);
        chk("rstmid_no_resp", obs_done,  0);
        chk("rstmid_ready2",  req_ready, 1);

        // Back-to-back SB then LHU
        preload(12, 32'h11223344);
        do_req(3'b101, 32'hBFC00031, 32'hFFFFFF85);
        do_req(3'b011, 32'hBFC00030, 32'd0);
        wait_resp();
        chk("lhu_rdata", obs_rdata, 32'h00008544);
        chk("lhu_be",    obs_be,    4'b0011);

        // Randomized traffic with random stalls
        rand_stall = 1'b1;
        for (int i = 0; i < 300; i++) begin
            do_req(3'($urandom_range(0, 7)), RV | 32'($urandom_range(0, 255)), $urandom);
        end
        wait_resp();
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
